// File: rtl/udp_payload_trim_64.sv
// udp_payload_trim_64: trims UDP payload to udp_length-8 bytes and forwards a registered header copy.
// Flags truncated payloads and illegal UDP lengths with one-cycle pulses.
module udp_payload_trim_64 #(
    parameter int MIN_UDP_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_udp_hdr_valid,
    output logic        s_udp_hdr_ready,
    input  logic [31:0] s_ip_source_ip,
    input  logic [31:0] s_ip_dest_ip,
    input  logic [15:0] s_udp_source_port,
    input  logic [15:0] s_udp_dest_port,
    input  logic [15:0] s_udp_length,
    input  logic [15:0] s_udp_checksum,
    input  logic [63:0] s_udp_payload_axis_tdata,
    input  logic [7:0]  s_udp_payload_axis_tkeep,
    input  logic        s_udp_payload_axis_tvalid,
    output logic        s_udp_payload_axis_tready,
    input  logic        s_udp_payload_axis_tlast,
    input  logic        s_udp_payload_axis_tuser,
    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [31:0] m_ip_source_ip,
    output logic [31:0] m_ip_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [15:0] m_udp_checksum,
    output logic [63:0] m_udp_payload_axis_tdata,
    output logic [7:0]  m_udp_payload_axis_tkeep,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,
    output logic        busy,
    output logic        error_payload_early_termination,
    output logic        error_bad_length
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;
    state_t      state;
    logic [15:0] remaining;
    logic [3:0]  n;
    logic [7:0]  trim_keep;
    logic        hdr_fire, beat_fire, fits, len_ok, len_zero;

    always_comb begin
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b0, s_udp_payload_axis_tkeep[i]};
    end

    assign s_udp_hdr_ready = state == IDLE && !m_udp_hdr_valid;
    assign s_udp_payload_axis_tready = state == PAYLOAD ? (m_udp_payload_axis_tready || !m_udp_payload_axis_tvalid)
                                                        : state == DROP;
    assign busy      = state != IDLE;
    assign hdr_fire  = s_udp_hdr_valid && s_udp_hdr_ready;
    assign beat_fire = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
    assign len_ok    = s_udp_length >= 16'(MIN_UDP_LEN);
    assign len_zero  = s_udp_length == 16'(MIN_UDP_LEN);
    assign fits      = remaining <= {12'd0, n};
    // only consulted when remaining <= 8, so the low nibble is the whole count
    assign trim_keep = ~(8'hFF << remaining[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                           <= IDLE;
            remaining                       <= '0;
            m_udp_hdr_valid                 <= 1'b0;
            m_ip_source_ip                  <= '0;
            m_ip_dest_ip                    <= '0;
            m_udp_source_port               <= '0;
            m_udp_dest_port                 <= '0;
            m_udp_length                    <= '0;
            m_udp_checksum                  <= '0;
            m_udp_payload_axis_tdata        <= '0;
            m_udp_payload_axis_tkeep        <= '0;
            m_udp_payload_axis_tvalid       <= 1'b0;
            m_udp_payload_axis_tlast        <= 1'b0;
            m_udp_payload_axis_tuser        <= 1'b0;
            error_payload_early_termination <= 1'b0;
            error_bad_length                <= 1'b0;
        end else begin
            error_payload_early_termination <= 1'b0;
            error_bad_length                <= 1'b0;
            if (m_udp_hdr_ready) m_udp_hdr_valid <= 1'b0;
            if (m_udp_payload_axis_tready) m_udp_payload_axis_tvalid <= 1'b0;
            case (state)
                IDLE: if (hdr_fire) begin
                    m_ip_source_ip    <= s_ip_source_ip;
                    m_ip_dest_ip      <= s_ip_dest_ip;
                    m_udp_source_port <= s_udp_source_port;
                    m_udp_dest_port   <= s_udp_dest_port;
                    m_udp_length      <= s_udp_length;
                    m_udp_checksum    <= s_udp_checksum;
                    remaining         <= len_ok ? s_udp_length - 16'(MIN_UDP_LEN) : '0;
                    m_udp_hdr_valid   <= len_ok;
                    error_bad_length  <= !len_ok;
                    state             <= (!len_ok || len_zero) ? DROP : PAYLOAD;
                end
                PAYLOAD: if (beat_fire) begin
                    m_udp_payload_axis_tvalid <= 1'b1;
                    m_udp_payload_axis_tdata  <= s_udp_payload_axis_tdata;
                    if (fits) begin
                        m_udp_payload_axis_tkeep <= trim_keep;
                        m_udp_payload_axis_tlast <= 1'b1;
                        m_udp_payload_axis_tuser <= s_udp_payload_axis_tlast && s_udp_payload_axis_tuser;
                        state                    <= s_udp_payload_axis_tlast ? IDLE : DROP;
                    end else begin
                        m_udp_payload_axis_tkeep        <= s_udp_payload_axis_tkeep;
                        m_udp_payload_axis_tlast        <= s_udp_payload_axis_tlast;
                        m_udp_payload_axis_tuser        <= s_udp_payload_axis_tlast || s_udp_payload_axis_tuser;
                        error_payload_early_termination <= s_udp_payload_axis_tlast;
                        remaining                       <= remaining - {12'd0, n};
                        state                           <= s_udp_payload_axis_tlast ? IDLE : PAYLOAD;
                    end
                end
                DROP: if (beat_fire && s_udp_payload_axis_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
